// File: rtl/ex_ma_latch.sv
// EX->MA pipeline boundary: registers the ALU result and control bundle, owns the
// cmp-written flags register, resolves branches and keeps saturating debug counters.
module ex_ma_latch #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EX_valid,
    input  logic [DATA_W-1:0] EX_ALU_Result,
    input  logic [1:0]        EX_flags,
    input  logic              EX_isCmp,
    input  logic              EX_isBeq,
    input  logic              EX_isBgt,
    input  logic              EX_isUBranch,
    input  logic [DATA_W-1:0] EX_branchTarget,
    input  logic [DATA_W-1:0] EX_Op2,
    input  logic [DATA_W-1:0] EX_pc,
    input  logic [RD_W-1:0]   EX_rd,
    input  logic [3:0]        EX_MemWb_Signals,
    input  logic              MA_stall,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_pc,
    output logic [1:0]        flags_q,
    output logic              MA_valid,
    output logic [DATA_W-1:0] MA_ALU_Result,
    output logic [DATA_W-1:0] MA_Op2,
    output logic [DATA_W-1:0] MA_pc,
    output logic [RD_W-1:0]   MA_rd,
    output logic [3:0]        MA_MemWb_Signals,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    logic              accept;
    logic              cond;

    logic [1:0]        flags_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] aluRes_q, aluRes_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [3:0]        memWb_q, memWb_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [CNT_W-1:0]  taken_q, taken_d;

    assign accept = EX_valid & ~MA_stall;

    // Branches see the flags as they were before this cycle's cmp commits.
    assign cond = EX_isUBranch | (EX_isBeq & flags_q[0]) | (EX_isBgt & flags_q[1]);

    // rst_n gating drops an in-flight redirect the moment reset asserts.
    assign branch_taken = rst_n & accept & cond;
    assign branch_pc    = EX_branchTarget;

    always_comb begin
        flags_d   = flags_q;
        valid_d   = valid_q;
        aluRes_d  = aluRes_q;
        op2_d     = op2_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        memWb_d   = memWb_q;
        retired_d = retired_q;
        taken_d   = taken_q;

        if (accept && EX_isCmp) begin
            flags_d = EX_flags;
        end

        if (!MA_stall) begin
            valid_d  = EX_valid;
            aluRes_d = EX_ALU_Result;
            op2_d    = EX_Op2;
            pc_d     = EX_pc;
            rd_d     = EX_rd;
            memWb_d  = EX_valid ? EX_MemWb_Signals : 4'b0000;
        end

        if (accept && (retired_q != {CNT_W{1'b1}})) begin
            retired_d = retired_q + 1'b1;
        end

        if (branch_taken && (taken_q != {CNT_W{1'b1}})) begin
            taken_d = taken_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= 2'b00;
            valid_q   <= 1'b0;
            aluRes_q  <= '0;
            op2_q     <= '0;
            pc_q      <= '0;
            rd_q      <= '0;
            memWb_q   <= 4'b0000;
            retired_q <= '0;
            taken_q   <= '0;
        end else begin
            flags_q   <= flags_d;
            valid_q   <= valid_d;
            aluRes_q  <= aluRes_d;
            op2_q     <= op2_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            memWb_q   <= memWb_d;
            retired_q <= retired_d;
            taken_q   <= taken_d;
        end
    end

    assign MA_valid         = valid_q;
    assign MA_ALU_Result    = aluRes_q;
    assign MA_Op2           = op2_q;
    assign MA_pc            = pc_q;
    assign MA_rd            = rd_q;
    assign MA_MemWb_Signals = memWb_q;
    assign retired_cnt      = retired_q;
    assign taken_cnt        = taken_q;

endmodule

// File: tb/tb_ex_ma_latch.sv
// Directed bench for ex_ma_latch; a second CNT_W=4 instance shares all inputs
// so counter saturation can be reached quickly.
module tb_ex_ma_latch;

    localparam int DATA_W = 32;
    localparam int RD_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              EX_valid;
    logic [DATA_W-1:0] EX_ALU_Result;
    logic [1:0]        EX_flags;
    logic              EX_isCmp, EX_isBeq, EX_isBgt, EX_isUBranch;
    logic [DATA_W-1:0] EX_branchTarget, EX_Op2, EX_pc;
    logic [RD_W-1:0]   EX_rd;
    logic [3:0]        EX_MemWb_Signals;
    logic              MA_stall;

    logic              branchTaken, branchTaken4;
    logic [DATA_W-1:0] branchPc, branchPc4;
    logic [1:0]        flagsQ, flagsQ4;
    logic              maValid, maValid4;
    logic [DATA_W-1:0] maAlu, maAlu4, maOp2, maOp24, maPc, maPc4;
    logic [RD_W-1:0]   maRd, maRd4;
    logic [3:0]        maMemWb, maMemWb4;
    logic [15:0]       retiredCnt, takenCnt;
    logic [3:0]        retiredCnt4, takenCnt4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_ma_latch #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .EX_valid(EX_valid), .EX_ALU_Result(EX_ALU_Result),
        .EX_flags(EX_flags), .EX_isCmp(EX_isCmp), .EX_isBeq(EX_isBeq), .EX_isBgt(EX_isBgt),
        .EX_isUBranch(EX_isUBranch), .EX_branchTarget(EX_branchTarget), .EX_Op2(EX_Op2),
        .EX_pc(EX_pc), .EX_rd(EX_rd), .EX_MemWb_Signals(EX_MemWb_Signals), .MA_stall(MA_stall),
        .branch_taken(branchTaken), .branch_pc(branchPc), .flags_q(flagsQ), .MA_valid(maValid),
        .MA_ALU_Result(maAlu), .MA_Op2(maOp2), .MA_pc(maPc), .MA_rd(maRd),
        .MA_MemWb_Signals(maMemWb), .retired_cnt(retiredCnt), .taken_cnt(takenCnt)
    );

    ex_ma_latch #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .EX_valid(EX_valid), .EX_ALU_Result(EX_ALU_Result),
        .EX_flags(EX_flags), .EX_isCmp(EX_isCmp), .EX_isBeq(EX_isBeq), .EX_isBgt(EX_isBgt),
        .EX_isUBranch(EX_isUBranch), .EX_branchTarget(EX_branchTarget), .EX_Op2(EX_Op2),
        .EX_pc(EX_pc), .EX_rd(EX_rd), .EX_MemWb_Signals(EX_MemWb_Signals), .MA_stall(MA_stall),
        .branch_taken(branchTaken4), .branch_pc(branchPc4), .flags_q(flagsQ4), .MA_valid(maValid4),
        .MA_ALU_Result(maAlu4), .MA_Op2(maOp24), .MA_pc(maPc4), .MA_rd(maRd4),
        .MA_MemWb_Signals(maMemWb4), .retired_cnt(retiredCnt4), .taken_cnt(takenCnt4)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] alu, input logic [1:0] fl,
                                 input logic cmp, input logic beq, input logic bgt, input logic ub,
                                 input logic [DATA_W-1:0] tgt, input logic [RD_W-1:0] rd,
                                 input logic [3:0] mw, input logic stall);
        EX_valid = v; EX_ALU_Result = alu; EX_flags = fl; EX_isCmp = cmp; EX_isBeq = beq;
        EX_isBgt = bgt; EX_isUBranch = ub; EX_branchTarget = tgt; EX_rd = rd;
        EX_MemWb_Signals = mw; MA_stall = stall;
        EX_Op2 = alu ^ 32'hFFFF_0000; EX_pc = alu + 32'h1000;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 32'h0, 2'b00, 0, 0, 0, 0, 32'h0, 4'd0, 4'b0000, 0);
        step();
        checkOutput("rst_valid", {63'd0, maValid}, 64'd0);
        checkOutput("rst_flags", {62'd0, flagsQ}, 64'd0);
        checkOutput("rst_retired", {48'd0, retiredCnt}, 64'd0);
        rst_n = 1'b1;

        // Pass-through then bubble
        applyStimulus(1, 32'h2A, 2'b11, 0, 0, 0, 0, 32'h0, 4'd5, 4'b0100, 0);
        step();
        checkOutput("pt_alu", {32'd0, maAlu}, 64'h2A);
        checkOutput("pt_op2", {32'd0, maOp2}, 64'hFFFF_002A);
        checkOutput("pt_pc", {32'd0, maPc}, 64'h102A);
        checkOutput("pt_rd", {60'd0, maRd}, 64'd5);
        checkOutput("pt_memwb", {60'd0, maMemWb}, 64'h4);
        checkOutput("pt_valid", {63'd0, maValid}, 64'd1);
        checkOutput("pt_retired", {48'd0, retiredCnt}, 64'd1);
        checkOutput("pt_flags_hold", {62'd0, flagsQ}, 64'd0);
        applyStimulus(0, 32'h2A, 2'b00, 0, 0, 0, 0, 32'h0, 4'd5, 4'b0100, 0);
        step();
        checkOutput("bub_valid", {63'd0, maValid}, 64'd0);
        checkOutput("bub_memwb", {60'd0, maMemWb}, 64'h0);
        checkOutput("bub_retired", {48'd0, retiredCnt}, 64'd1);

        // cmp(E) then beq: taken on the fresh flags
        applyStimulus(1, 32'h11, 2'b01, 1, 0, 0, 0, 32'h0, 4'd0, 4'b0000, 0);
        #1 checkOutput("cmp_no_branch", {63'd0, branchTaken}, 64'd0);
        step();
        checkOutput("cmp_flags", {62'd0, flagsQ}, 64'h1);
        applyStimulus(1, 32'h12, 2'b10, 0, 1, 0, 0, 32'h100, 4'd0, 4'b0000, 0);
        #1 checkOutput("beq_taken", {63'd0, branchTaken}, 64'd1);
        checkOutput("beq_pc", {32'd0, branchPc}, 64'h100);
        step();
        checkOutput("beq_taken_cnt", {48'd0, takenCnt}, 64'd1);
        checkOutput("beq_flags_hold", {62'd0, flagsQ}, 64'h1);
        checkOutput("beq_retired", {48'd0, retiredCnt}, 64'd3);

        // cmp(GT): beq not taken, bgt taken
        applyStimulus(1, 32'h13, 2'b10, 1, 0, 0, 0, 32'h0, 4'd0, 4'b0000, 0);
        step();
        checkOutput("cmp2_flags", {62'd0, flagsQ}, 64'h2);
        applyStimulus(1, 32'h14, 2'b01, 0, 1, 0, 0, 32'h100, 4'd0, 4'b0000, 0);
        #1 checkOutput("beq_not_taken", {63'd0, branchTaken}, 64'd0);
        step();
        checkOutput("beq_nt_cnt", {48'd0, takenCnt}, 64'd1);
        applyStimulus(1, 32'h55, 2'b00, 0, 0, 1, 0, 32'h200, 4'd0, 4'b0000, 0);
        #1 checkOutput("bgt_taken", {63'd0, branchTaken}, 64'd1);
        checkOutput("bgt_pc", {32'd0, branchPc}, 64'h200);
        step();
        checkOutput("bgt_taken_cnt", {48'd0, takenCnt}, 64'd2);
        checkOutput("bgt_retired", {48'd0, retiredCnt}, 64'd6);

        // Unconditional branch held in EX under stall
        applyStimulus(1, 32'h77, 2'b00, 0, 0, 0, 1, 32'h300, 4'd9, 4'b1000, 1);
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput("stall_no_branch", {63'd0, branchTaken}, 64'd0);
            step();
            checkOutput("stall_alu_hold", {32'd0, maAlu}, 64'h55);
            checkOutput("stall_retired", {48'd0, retiredCnt}, 64'd6);
            checkOutput("stall_taken", {48'd0, takenCnt}, 64'd2);
        end
        MA_stall = 1'b0;
        #1 checkOutput("release_taken", {63'd0, branchTaken}, 64'd1);
        checkOutput("release_pc", {32'd0, branchPc}, 64'h300);
        step();
        checkOutput("release_alu", {32'd0, maAlu}, 64'h77);
        checkOutput("release_memwb", {60'd0, maMemWb}, 64'h8);
        checkOutput("release_taken_cnt", {48'd0, takenCnt}, 64'd3);
        checkOutput("release_retired", {48'd0, retiredCnt}, 64'd7);

        // Stalled cmp must not commit until accepted
        applyStimulus(1, 32'h88, 2'b01, 1, 0, 0, 0, 32'h0, 4'd0, 4'b0000, 1);
        step();
        checkOutput("stcmp_hold", {62'd0, flagsQ}, 64'h2);
        MA_stall = 1'b0;
        step();
        checkOutput("stcmp_commit", {62'd0, flagsQ}, 64'h1);
        checkOutput("stcmp_retired", {48'd0, retiredCnt}, 64'd8);

        // 20 non-cmp instructions: 4-bit counter pins at 0xF, flags untouched
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 32'h900 + i, 2'b10, 0, 0, 0, 0, 32'h0, 4'd1, 4'b0100, 0);
            step();
        end
        checkOutput("sat_retired4", {60'd0, retiredCnt4}, 64'hF);
        checkOutput("sat_retired16", {48'd0, retiredCnt}, 64'd28);
        checkOutput("sat_taken4", {60'd0, takenCnt4}, 64'd3);
        checkOutput("sat_flags", {62'd0, flagsQ}, 64'h1);
        step();
        checkOutput("sat_retired4_stay", {60'd0, retiredCnt4}, 64'hF);

        // Taken 4-bit counter saturation
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, 32'hA00 + i, 2'b00, 0, 0, 0, 1, 32'h400, 4'd0, 4'b0000, 0);
            step();
        end
        checkOutput("sat_taken4_max", {60'd0, takenCnt4}, 64'hF);
        checkOutput("sat_taken16", {48'd0, takenCnt}, 64'd17);

        // Async reset mid-cycle with a redirect in flight
        applyStimulus(1, 32'hBEEF, 2'b00, 0, 0, 0, 1, 32'h500, 4'd3, 4'b0110, 0);
        #1 checkOutput("pre_rst_taken", {63'd0, branchTaken}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("arst_taken", {63'd0, branchTaken}, 64'd0);
        checkOutput("arst_valid", {63'd0, maValid}, 64'd0);
        checkOutput("arst_flags", {62'd0, flagsQ}, 64'd0);
        checkOutput("arst_retired", {48'd0, retiredCnt}, 64'd0);
        checkOutput("arst_taken_cnt", {48'd0, takenCnt}, 64'd0);
        checkOutput("arst_alu", {32'd0, maAlu}, 64'd0);
        checkOutput("arst_memwb", {60'd0, maMemWb}, 64'd0);
        checkOutput("arst_retired4", {60'd0, retiredCnt4}, 64'd0);
        step();
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
